// File: rtl/keccak_chi_share_encoder_pkg.sv
// Shared constants, FIFO state type and share-encoding helper for the
// keccak chi share encoder.
package keccak_chi_share_encoder_pkg;

  localparam int unsigned ROW_W    = 5;
  localparam int unsigned N_SHARES = 3;
  localparam int unsigned RND_W    = 10;
  localparam int unsigned ENT_W    = ROW_W * N_SHARES;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_t;

  // Packs {s3, s2, s1}; s3 is formed straight from the row so the
  // unshared value only ever exists combinationally.
  function automatic logic [ENT_W-1:0] encode_row(
    input logic [ROW_W-1:0] row,
    input logic [RND_W-1:0] rnd
  );
    logic [ROW_W-1:0] m1;
    logic [ROW_W-1:0] m2;
    m1 = rnd[ROW_W-1:0];
    m2 = rnd[RND_W-1:ROW_W];
    return {row ^ m1 ^ m2, m2, m1};
  endfunction

endpackage

// File: rtl/keccak_chi_share_encoder_share_fifo2.sv
// Two-entry FIFO of 15-bit share triples. Entries that are not valid are
// held at zero so no stale share is ever visible on dout.
module share_fifo2
  import keccak_chi_share_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [ENT_W-1:0] din,
  output logic [ENT_W-1:0] dout,
  output logic             full,
  output logic             not_empty
);

  fifo_state_t      state;
  logic [ENT_W-1:0] e0;
  logic [ENT_W-1:0] e1;

  // Occupancy state machine with entry storage; e0 is always the oldest row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      e0    <= '0;
      e1    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            e0    <= din;
            state <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              e1    <= din;
              state <= TWO;
            end
            2'b01: begin
              e0    <= '0;
              state <= EMPTY;
            end
            2'b11: e0 <= din;
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            e0    <= e1;
            e1    <= '0;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign dout      = e0;
  assign full      = (state == TWO);
  assign not_empty = (state != EMPTY);

endmodule

// File: rtl/keccak_chi_share_encoder.sv
// Keccak chi share encoder: splits each plaintext row into three Boolean
// shares using fresh randomness and buffers them in a 2-entry FIFO.
// Optional debug feature: define SHARE_CHECK_EN to add the share_err port
// and a parity FIFO that checks s1^s2^s3 against the accepted row.
module keccak_chi_share_encoder
  import keccak_chi_share_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_row,
  input  logic             rnd_valid,
  output logic             rnd_ready,
  input  logic [RND_W-1:0] rnd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_s1,
  output logic [ROW_W-1:0] out_s2,
  output logic [ROW_W-1:0] out_s3,
  output logic [CNT_W-1:0] row_cnt
`ifdef SHARE_CHECK_EN
  ,
  output logic             share_err
`endif
);

  logic             full;
  logic             accept;
  logic             pop;
  logic [ENT_W-1:0] fifo_dout;

  // rst_n gates the readies so they drop the instant reset asserts.
  assign in_ready  = rst_n & rnd_valid & ~full;
  assign rnd_ready = rst_n & in_valid & ~full;
  assign accept    = in_valid & rnd_valid & ~full;
  assign pop       = out_valid & out_ready;

  share_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .pop       (pop),
    .din       (encode_row(in_row, rnd)),
    .dout      (fifo_dout),
    .full      (full),
    .not_empty (out_valid)
  );

  assign out_s1 = fifo_dout[ROW_W-1:0];
  assign out_s2 = fifo_dout[2*ROW_W-1:ROW_W];
  assign out_s3 = fifo_dout[3*ROW_W-1:2*ROW_W];

  // Count accepted rows, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
    end else if (accept) begin
      row_cnt <= row_cnt + CNT_W'(1);
    end
  end

`ifdef SHARE_CHECK_EN
  logic par0;
  logic par1;
  logic par_in;

  assign par_in = ^in_row;

  // Parity shadow FIFO tracking the share FIFO via its full/not_empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par0 <= 1'b0;
      par1 <= 1'b0;
    end else begin
      case ({full, out_valid, accept, pop})
        4'b0010: par0 <= par_in;
        4'b0111: par0 <= par_in;
        4'b0110: par1 <= par_in;
        4'b0101: par0 <= 1'b0;
        4'b1101: begin
          par0 <= par1;
          par1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Sticky error when a popped triple does not recombine to the stored parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      share_err <= 1'b0;
    end else if (pop && ((^(out_s1 ^ out_s2 ^ out_s3)) != par0)) begin
      share_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_keccak_chi_share_encoder.sv
module tb_keccak_chi_share_encoder;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          rnd_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [4:0]    in_row = '0;
  logic [9:0]    rnd = '0;
  logic          in_ready;
  logic          rnd_ready;
  logic          out_valid;
  logic [4:0]    out_s1;
  logic [4:0]    out_s2;
  logic [4:0]    out_s3;
  logic [CW-1:0] row_cnt;
`ifdef SHARE_CHECK_EN
  logic          share_err;
`endif

  keccak_chi_share_encoder #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .rnd       (rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s1    (out_s1),
    .out_s2    (out_s2),
    .out_s3    (out_s3),
    .row_cnt   (row_cnt)
`ifdef SHARE_CHECK_EN
    ,
    .share_err (share_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: queue of expected share triples (capacity 2) and a
  // row counter modulo 2^CW.
  typedef struct {
    int s1;
    int s2;
    int s3;
  } trip_t;
  trip_t q[$];
  int    cnt = 0;

  typedef struct {
    logic [4:0] row;
    logic [9:0] r;
    logic [4:0] e1;
    logic [4:0] e2;
    logic [4:0] e3;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic trip_t model_shares(input int row, input int r);
    trip_t t;
    t.s1 = r % 32;
    t.s2 = r / 32;
    t.s3 = row ^ t.s1 ^ t.s2;
    return t;
  endfunction

  task automatic check_out();
    trip_t e;
    e = '{0, 0, 0};
    if (q.size() != 0) e = q[0];
    chk("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
    chk("out_s1", int'(out_s1), e.s1);
    chk("out_s2", int'(out_s2), e.s2);
    chk("out_s3", int'(out_s3), e.s3);
    chk("row_cnt", int'(row_cnt), cnt);
  endtask

  // Starts and ends on a falling edge: drive, check readies, clock, check outputs.
  task automatic cycle(input bit iv, input bit rv, input bit orr,
                       input logic [4:0] row, input logic [9:0] r);
    bit acc;
    bit pp;
    in_valid  = iv;
    rnd_valid = rv;
    out_ready = orr;
    in_row    = row;
    rnd       = r;
    #1;
    chk("in_ready", int'(in_ready), (rv && q.size() < 2) ? 1 : 0);
    chk("rnd_ready", int'(rnd_ready), (iv && q.size() < 2) ? 1 : 0);
    acc = iv && rv && (q.size() < 2);
    pp  = orr && (q.size() != 0);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) begin
      q.push_back(model_shares(int'(row), int'(r)));
      cnt = (cnt + 1) % (1 << CW);
    end
    @(negedge clk);
    check_out();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [4:0] hold_s1;
  logic [4:0] hold_s3;
  trip_t      t;

  initial begin
    tbl[0] = '{5'h1B, 10'h2A5, 5'h05, 5'h15, 5'h0B};
    tbl[1] = '{5'h00, 10'h000, 5'h00, 5'h00, 5'h00};
    tbl[2] = '{5'h1F, 10'h3FF, 5'h1F, 5'h1F, 5'h1F};
    tbl[3] = '{5'h1F, 10'h000, 5'h00, 5'h00, 5'h1F};
    tbl[4] = '{5'h0A, 10'h0C3, 5'h03, 5'h06, 5'h0F};

    // Reset state with valids already high
    in_valid  = 1'b1;
    rnd_valid = 1'b1;
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_rnd_ready", int'(rnd_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_row_cnt", int'(row_cnt), 0);
    chk("rst_s3", int'(out_s3), 0);
    do_reset();

    // Table-driven single-row encodes
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 1, tbl[i].row, tbl[i].r);
      chk("tbl_s1", int'(out_s1), int'(tbl[i].e1));
      chk("tbl_s2", int'(out_s2), int'(tbl[i].e2));
      chk("tbl_s3", int'(out_s3), int'(tbl[i].e3));
      chk("tbl_row_cnt", int'(row_cnt), (2 * i + 1) % 16);
      cycle(0, 0, 1, '0, '0);
      chk("tbl_drained", int'(out_valid), 0);
      cycle(1, 1, 0, 5'h00, 10'h000);
      cycle(0, 0, 1, '0, '0);
    end

    // Backpressure: two rows fill the FIFO, third is refused, outputs hold
    cycle(1, 1, 0, 5'h11, 10'h123);
    hold_s1 = out_s1;
    hold_s3 = out_s3;
    cycle(1, 1, 0, 5'h02, 10'h3C1);
    cycle(1, 1, 0, 5'h07, 10'h055);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_rnd_ready", int'(rnd_ready), 0);
    cycle(1, 1, 0, 5'h07, 10'h055);
    chk("hold_s1", int'(out_s1), int'(hold_s1));
    chk("hold_s3", int'(out_s3), int'(hold_s3));
    cycle(0, 0, 1, '0, '0);
    chk("drain2_s1", int'(out_s1), 5'h01);
    cycle(0, 0, 1, '0, '0);
    chk("drain_empty", int'(out_valid), 0);

    // Row present without randomness: no accept until rnd_valid rises
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 1, 5'h13, 10'h1E7);
      chk("norand_rnd_ready", int'(rnd_ready), 1);
      chk("norand_in_ready", int'(in_ready), 0);
      chk("norand_valid", int'(out_valid), 0);
    end
    cycle(1, 1, 1, 5'h13, 10'h1E7);
    chk("rnd_rise_accept", int'(out_valid), 1);

    // ONE state with simultaneous push and pop
    cycle(1, 1, 1, 5'h0C, 10'h2F0);
    t = model_shares(5'h0C, 10'h2F0);
    chk("pushpop_valid", int'(out_valid), 1);
    chk("pushpop_s3", int'(out_s3), t.s3);
    chk("pushpop_depth", q.size(), 1);
    cycle(0, 0, 1, '0, '0);
    chk("pushpop_empty", int'(out_valid), 0);

    // Counter wrap at CNT_W=4
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1, 1, 1, 5'($urandom), 10'($urandom));
    chk("wrap_row_cnt", int'(row_cnt), 1);
    cycle(0, 0, 1, '0, '0);

    // Asynchronous reset mid-drain
    cycle(1, 1, 0, 5'h15, 10'h0AA);
    cycle(1, 1, 0, 5'h0E, 10'h355);
    cycle(0, 1, 1, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_s1", int'(out_s1), 0);
    chk("arst_s2", int'(out_s2), 0);
    chk("arst_s3", int'(out_s3), 0);
    chk("arst_row_cnt", int'(row_cnt), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    q.delete();
    cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 1, 1, 5'h1B, 10'h2A5);
    chk("post_rst_accept", int'(out_s3), 5'h0B);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 3) != 0, 5'($urandom), 10'($urandom));
    end

`ifdef SHARE_CHECK_EN
    chk("share_err_clean", int'(share_err), 0);
    do_reset();
    cycle(1, 1, 0, 5'h1B, 10'h2A5);
    force dut.out_s3 = 5'h0A;
    in_valid  = 1'b0;
    rnd_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    release dut.out_s3;
    void'(q.pop_front());
    chk("share_err_set", int'(share_err), 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 5'($urandom), 10'($urandom));
    chk("share_err_sticky", int'(share_err), 1);
    do_reset();
    #1;
    chk("share_err_reset", int'(share_err), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keccak_chi_share_encoder.md
KECCAK_CHI_SHARE_ENCODER -- requirements
Module: keccak_chi_share_encoder

Interface
REQ-001 Parameter: CNT_W, default 16, width of the encoded-row counter.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  an unshared chi row is present on in_row.
REQ-005 Port: in_ready  output  1  the encoder accepts in_row this cycle.
REQ-006 Port: in_row  input  5  plaintext row; bit0..bit4 = S-box inputs a..e.
REQ-007 Port: rnd_valid  input  1  fresh randomness is present on rnd.
REQ-008 Port: rnd_ready  output  1  the encoder consumes rnd this cycle.
REQ-009 Port: rnd  input  10  randomness; rnd[4:0] is mask m1, rnd[9:5] is mask m2.
REQ-010 Port: out_valid  output  1  a 3-share row is present on out_s1/out_s2/out_s3.
REQ-011 Port: out_ready  input  1  the downstream masked chi S-box accepts the row.
REQ-012 Port: out_s1, out_s2, out_s3  output  5 each  share k of bit i drives share index k of S-box input i.
REQ-013 Port: row_cnt  output  CNT_W  count of rows accepted since reset.

Function
REQ-014 A row and its randomness SHALL be accepted together: accept = in_valid & rnd_valid & !full.
REQ-015 in_ready SHALL equal rnd_valid & !full; rnd_ready SHALL equal in_valid & !full; neither depends on out_ready (no combinational ready path).
REQ-016 Share computation: s1 = m1, s2 = m2, s3 = in_row ^ m1 ^ m2, so that s1^s2^s3 = in_row.
REQ-017 s3 SHALL be computed and registered in one step; the unshared in_row SHALL never be stored in a register.
REQ-018 Accepted rows SHALL enter a 2-entry FIFO; a row accepted in cycle N SHALL be visible on the outputs at cycle N+1 when the FIFO was empty.
REQ-019 FIFO states: EMPTY -> ONE on push; ONE -> TWO on push without pop; ONE -> EMPTY on pop without push; ONE stays ONE on simultaneous push and pop; TWO -> ONE on pop; full = (state == TWO).
REQ-020 out_valid SHALL be 1 exactly when the state is not EMPTY; the outputs SHALL show the oldest entry and SHALL hold stable while out_valid & !out_ready.
REQ-021 A pop SHALL occur on out_valid & out_ready; the order of rows SHALL be preserved.
REQ-022 row_cnt SHALL increment by 1 on each accept and wrap from 2^CNT_W-1 to 0.
REQ-023 Shares of entries that are not valid SHALL read as 0, so no stale share remains on the outputs.

Reset
REQ-024 Asserting rst_n low SHALL immediately force: state EMPTY, out_valid 0, shares 0, row_cnt 0, in_ready 0, rnd_ready 0.
REQ-025 Rows in flight when reset is asserted SHALL be discarded, with no partial output.
REQ-026 The first accept after rst_n rises SHALL be possible in the first rising clock edge after release.

Configuration
REQ-027 Macro: SHARE_CHECK_EN (debug builds only).
REQ-028 With SHARE_CHECK_EN defined: an extra output port share_err (1 bit) and a parity-bit FIFO holding the XOR-reduction of the accepted in_row; share_err SHALL be set sticky on a pop whose XOR-reduction of s1^s2^s3 mismatches the stored parity; share_err is cleared only by reset.
REQ-029 Without SHARE_CHECK_EN: no share_err port and no parity logic; behaviour is otherwise identical.

Structure
REQ-030 A shared package SHALL hold ROW_W = 5, N_SHARES = 3, RND_W = 10, and the FIFO state enum {EMPTY, ONE, TWO}.
REQ-031 One sub-module, share_fifo2, SHALL implement the 2-entry 15-bit FIFO and its state machine; the top level holds the share computation, the handshake logic and the counter.

Verification
REQ-032 Reset, then in_row=5'h1B, rnd=10'h2A5, both valid, out_ready=1: at the next cycle, out_s1=5'h05, out_s2=5'h15, out_s3=5'h0B, row_cnt=1.
REQ-033 out_ready=0, 3 rows offered back-to-back: 2 rows accepted, then in_ready=0 and rnd_ready=0; the outputs stay stable; after out_ready=1, the rows drain in order.
REQ-034 in_valid=1, rnd_valid=0 for 4 cycles: no accept, rnd_ready=1, in_ready=0, row_cnt unchanged; the accept occurs on the cycle rnd_valid rises.
REQ-035 FIFO in ONE state with simultaneous push and pop: the state stays ONE, the new row appears next cycle, and no row is lost.
REQ-036 CNT_W=4, 17 accepts: row_cnt=1; rst_n pulsed low mid-drain: out_valid=0 and shares=0 asynchronously.
REQ-037 With SHARE_CHECK_EN, corrupt out_s3 bit0 via force: share_err=1 after the pop and it stays 1 until reset; 1000 random rows without corruption: share_err=0.
